muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit downstream of the register file. It takes the two register read operands, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a fixed multi-cycle latency, and drives the register file's write port (write data, destination index, write enable). A start/busy/done handshake lets the control unit stall while the unit is busy.

Parameters:
BUS_WIDTH, 32, operand/result width in bits; must be even and >= 4.
REG_ADDR_W, 5, destination register index width; 32 architectural registers.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  input  BUS_WIDTH  rs1 value, i.e. register file read data 1.
op_b  input  BUS_WIDTH  rs2 value, i.e. register file read data 2.
rd_in  input  REG_ADDR_W  destination register index.
busy  output  1  high from the cycle after start is accepted until done drops.
done  output  1  one-cycle pulse; result valid.
result  output  BUS_WIDTH  register file write data; held until the next accepted start.
rd_out  output  REG_ADDR_W  register file write index; held with result.
wr_en  output  1  register file write strobe; equals done AND (rd_out != 0).

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, wr_en = 0; result = 0; rd_out = 0; all internal registers cleared. An operation in flight is discarded and no write is issued.
- States: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
- IDLE: on start=1, latch funct3, rd_in, the operand magnitudes and the sign flags, clear the accumulators, and load count=BUS_WIDTH-1. Go to CALC. busy rises the next cycle.
- CALC: each cycle processes one bit. Multiply: shift-add on magnitudes, 2*BUS_WIDTH product. Divide: restoring shift-subtract on magnitudes. After the cycle with count==0, go to FIXUP. Otherwise count decrements.
- Sign rules:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Product negated when the operand signs differ.
  - Quotient negated when the signs differ. Remainder takes the dividend's sign.
- FIXUP: apply negation and select the result.
  - MUL: low half of the product. MULH/MULHSU/MULHU: high half.
  - Divisor==0: quotient = all ones (both signed and unsigned), remainder = dividend unchanged.
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend, remainder = 0.
  - Go to DONE.
- DONE: done=1 for exactly one cycle. result and rd_out are registered and valid in this cycle. wr_en=1 only if rd_out != 0. Then return to IDLE with busy=0.
- Latency is fixed for all ops and operand values, including the special cases. If start is sampled at edge N, done is high in the cycle following edge N+BUS_WIDTH+1.
- start while busy, or in the DONE cycle: ignored and not queued. The control unit holds start until it observes done.
- Operand inputs and funct3 may change freely after acceptance. The unit uses only the latched copies.
- result and rd_out hold their value after done until the next accepted start. They do not change during CALC (a separate result register is used).

Test Plan:
- MUL: op_a=7, op_b=0xFFFFFFFD (-3), rd_in=5 -> after 34 cycles, done pulse with result=0xFFFFFFEB, rd_out=5, wr_en=1. busy was high for 33 cycles before the pulse.
- High-half products:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- Signed divide: DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases, each with the same 34-cycle latency:
  - DIVU 0x1234/0 -> 0xFFFFFFFF. REM 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Handshake:
  - rd_in=0 -> done pulses, wr_en stays 0.
  - Second start asserted mid-CALC with different operands -> ignored; first result unchanged.
  - Back-to-back starts, one issued right after done -> both complete.
- Reset mid-CALC: assert rst_n=0 asynchronously at cycle 10 -> busy, done, wr_en, result, rd_out read 0 immediately. No done pulse follows. A new start after release completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register file write port.
// One operand bit per cycle on sign-stripped magnitudes, followed by a single
// FIXUP cycle that restores signs, resolves the special cases and picks the
// result. Latency is the same for every op and every operand value.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; result/rd_out hold the last answer
//   CALC  | one shift-add / shift-subtract step per cycle, BUS_WIDTH steps
//   FIXUP | sign correction, divide special cases, result select
//   DONE  | done/wr_en pulse, result valid
module muldiv_unit #(
  parameter int BUS_WIDTH  = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [BUS_WIDTH-1:0]  op_a,
  input  logic [BUS_WIDTH-1:0]  op_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BUS_WIDTH-1:0]  result,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  wr_en
);

  localparam int W  = BUS_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0]  COUNT_INIT = CW'(W - 1);
  localparam logic [W-1:0]   ONE_W      = W'(1);
  localparam logic [2*W-1:0] ONE_2W     = (2 * W)'(1);
  localparam logic [W-1:0]   MIN_NEG    = {1'b1, {(W-1){1'b0}}};

  logic [1:0]            state;
  logic [CW-1:0]         count;

  // latched operation context
  logic [2:0]            f3_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  sa_q, sb_q;
  logic [W-1:0]          mag_a_q, mag_b_q;

  // {acc_hi, acc_lo}: product while multiplying, {remainder, quotient} while dividing
  logic [W-1:0]          acc_hi, acc_lo;

  // ---------------------------------------------------------------------
  // Operand decode at acceptance
  // ---------------------------------------------------------------------
  logic         a_signed, b_signed;
  logic         sa_in, sb_in;
  logic [W-1:0] mag_a_in, mag_b_in;

  // Which operands are treated as two's complement for the incoming funct3
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010: a_signed = 1'b1;
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase
  end

  assign sa_in    = a_signed & op_a[W-1];
  assign sb_in    = b_signed & op_b[W-1];
  assign mag_a_in = sa_in ? (~op_a + ONE_W) : op_a;
  assign mag_b_in = sb_in ? (~op_b + ONE_W) : op_b;

  // ---------------------------------------------------------------------
  // Per-cycle datapath steps
  // ---------------------------------------------------------------------
  logic [W:0] mul_sum;
  logic [W:0] div_shift;
  logic [W:0] div_diff;

  // Multiply adds the multiplicand when the current multiplier bit is set;
  // divide trial-subtracts the divisor from the shifted partial remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a_q} : {(W+1){1'b0}});
    div_shift = {acc_hi, acc_lo[W-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
  end

  // ---------------------------------------------------------------------
  // Sign fixup and result select
  // ---------------------------------------------------------------------
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quot_fix, rem_fix, dividend;
  logic           div_zero, div_ovf;
  logic [W-1:0]   res_fix;

  // Restore signs, apply div-by-zero / overflow rules, pick the half or quotient/remainder
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = (sa_q ^ sb_q) ? (~prod + ONE_2W) : prod;
    quot_fix = (sa_q ^ sb_q) ? (~acc_lo + ONE_W) : acc_lo;
    rem_fix  = sa_q ? (~acc_hi + ONE_W) : acc_hi;
    dividend = sa_q ? (~mag_a_q + ONE_W) : mag_a_q;
    div_zero = (mag_b_q == '0);
    // only the signed ops can set sa_q/sb_q, so this is MIN / -1
    div_ovf  = sa_q && sb_q && (mag_a_q == MIN_NEG) && (mag_b_q == ONE_W);
    res_fix  = '0;
    case (f3_q)
      3'b000:                 res_fix = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: res_fix = prod_fix[2*W-1:W];
      3'b100, 3'b101: begin
        if (div_zero)     res_fix = '1;
        else if (div_ovf) res_fix = dividend;
        else              res_fix = quot_fix;
      end
      default: begin
        if (div_zero)     res_fix = dividend;
        else if (div_ovf) res_fix = '0;
        else              res_fix = rem_fix;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM and registered outputs
  // ---------------------------------------------------------------------

  // Sequence IDLE -> CALC -> FIXUP -> DONE; result/rd_out load only on FIXUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wr_en  <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CALC;
            count <= COUNT_INIT;
            busy  <= 1'b1;
          end
        end
        S_CALC: begin
          if (count == '0) state <= S_FIXUP;
          else             count <= count - 1'b1;
        end
        S_FIXUP: begin
          state  <= S_DONE;
          done   <= 1'b1;
          wr_en  <= (rd_q != '0);
          result <= res_fix;
          rd_out <= rd_q;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Latch the operation on acceptance and run one iteration per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q    <= '0;
      rd_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
    end else if (state == S_IDLE && start) begin
      f3_q    <= funct3;
      rd_q    <= rd_in;
      sa_q    <= sa_in;
      sb_q    <= sb_in;
      mag_a_q <= mag_a_in;
      mag_b_q <= mag_b_in;
      acc_hi  <= '0;
      // dividend magnitude for divides, multiplier magnitude for multiplies
      acc_lo  <= funct3[2] ? mag_a_in : mag_b_in;
    end else if (state == S_CALC) begin
      if (f3_q[2]) begin
        if (!div_diff[W]) begin
          acc_hi <= div_diff[W-1:0];
          acc_lo <= {acc_lo[W-2:0], 1'b1};
        end else begin
          acc_hi <= div_shift[W-1:0];
          acc_lo <= {acc_lo[W-2:0], 1'b0};
        end
      end else begin
        acc_hi <= mul_sum[W:1];
        acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M results, fixed
// latency, handshake behaviour and asynchronous reset mid-operation.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, wr_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.BUS_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .wr_en  (wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op (unit must be IDLE), scramble inputs after acceptance,
  // wait for done, check everything, then step into IDLE again.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input bit inject);
    int lat;
    int busy_cnt;
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = ~f3;
    op_a   = ~a;
    op_b   = ~b;
    rd_in  = ~rd;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (inject && lat == 10) begin
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd5;
        op_b   = 32'd3;
        rd_in  = 5'd9;
      end
      if (inject && lat == 14) start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    chk_val({tag, " latency"}, lat, 33);
    chk_val({tag, " busy_cycles"}, busy_cnt, 33);
    chk_val({tag, " result"}, result, exp);
    chk_val({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    chk_val({tag, " wr_en"}, {31'd0, wr_en}, {31'd0, (rd != 5'd0)});
    chk_val({tag, " busy_in_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk_val({tag, " done_drop"}, {31'd0, done}, 32'd0);
    chk_val({tag, " busy_drop"}, {31'd0, busy}, 32'd0);
    chk_val({tag, " result_held"}, result, exp);
  endtask

  // Idle for n cycles, returning how many done pulses were seen
  task automatic count_dones(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
  endtask

  initial begin
    int seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    rd_in  = '0;
    #12;
    chk_val("reset busy",   {31'd0, busy},  32'd0);
    chk_val("reset done",   {31'd0, done},  32'd0);
    chk_val("reset wr_en",  {31'd0, wr_en}, 32'd0);
    chk_val("reset result", result,         32'd0);
    chk_val("reset rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("mul",        3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0);
    do_op("mulh",       3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0);
    do_op("mulhu",      3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0);
    do_op("mulhsu",     3'b010, 32'hFFFF_FFFF,  32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 1'b0);
    do_op("mulhu_1",    3'b011, 32'h8000_0000,  32'h0000_0002, 5'd9,  32'h0000_0001, 1'b0);
    do_op("div",        3'b100, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 1'b0);
    do_op("rem",        3'b110, 32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFF, 1'b0);
    do_op("divu",       3'b101, 32'd100,        32'd7,         5'd12, 32'd14,        1'b0);
    do_op("remu",       3'b111, 32'd100,        32'd7,         5'd13, 32'd2,         1'b0);
    do_op("divu_zero",  3'b101, 32'h0000_1234,  32'd0,         5'd14, 32'hFFFF_FFFF, 1'b0);
    do_op("rem_zero",   3'b110, 32'h0000_1234,  32'd0,         5'd15, 32'h0000_1234, 1'b0);
    do_op("div_zero_n", 3'b100, 32'hFFFF_FFFB,  32'd0,         5'd16, 32'hFFFF_FFFF, 1'b0);
    do_op("rem_zero_n", 3'b110, 32'hFFFF_FFFB,  32'd0,         5'd17, 32'hFFFF_FFFB, 1'b0);
    do_op("div_ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1'b0);
    do_op("rem_ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h0000_0000, 1'b0);
    do_op("rd_zero",    3'b000, 32'd6,          32'd7,         5'd0,  32'd42,        1'b0);

    // start raised mid-CALC must be neither honoured nor queued
    do_op("inject",     3'b101, 32'd1000,       32'd10,        5'd20, 32'd100,       1'b1);
    count_dones(40, seen);
    chk_val("inject no_queued_done", seen, 0);

    // back-to-back: second op issued the cycle after the first leaves DONE
    do_op("b2b_first",  3'b000, 32'd3,          32'd4,         5'd21, 32'd12,        1'b0);
    do_op("b2b_second", 3'b111, 32'd17,         32'd5,         5'd22, 32'd2,         1'b0);

    // asynchronous reset in the middle of CALC
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    rd_in  = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_val("rst_mid busy",   {31'd0, busy},   32'd0);
    chk_val("rst_mid done",   {31'd0, done},   32'd0);
    chk_val("rst_mid wr_en",  {31'd0, wr_en},  32'd0);
    chk_val("rst_mid result", result,          32'd0);
    chk_val("rst_mid rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, seen);
    chk_val("rst_mid no_done", seen, 0);
    chk_val("rst_mid idle result", result, 32'd0);

    do_op("after_rst",  3'b100, 32'd100,        32'hFFFF_FFF9, 5'd4,  32'hFFFF_FFF2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
